jk_bank_sequencer: RTL and testbench

Command-driven controller for a WIDTH-bit bank of JK flip-flops held inside the block. Each accepted command is decoded into per-bit J/K drive vectors and applied for a programmed number of clock edges, giving load, clear, set, toggle, up/down count and shift operations. It sits between a command-issuing master and the flip-flop bank. The J/K vectors are exported so the bank can be observed or mirrored externally.

---
 rtl/jk_bank_sequencer.sv | 166 ++++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a WIDTH-bit JK flip-flop bank; an op runs for N edges, then a one-cycle done.
// Latency: accept at t0, first q change at t0+1, done during the cycle after t0+N; cmd_ready is high only in IDLE.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_LOAD       = 3'd1;
  localparam logic [2:0] OP_CLEAR      = 3'd2;
  localparam logic [2:0] OP_SET        = 3'd3;
  localparam logic [2:0] OP_TOGGLE     = 3'd4;
  localparam logic [2:0] OP_COUNT_UP   = 3'd5;
  localparam logic [2:0] OP_SHIFT_LEFT = 3'd6;
  localparam logic [2:0] OP_COUNT_DOWN = 3'd7;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] bank_q, bank_d;

  logic [WIDTH-1:0] j_raw, k_raw, shift_j;
  logic             carry;
  logic [CNT_W-1:0] n_eff;

  assign shift_j = {bank_q[WIDTH-2:0], data_q[0]};

  // J/K decode of the latched op against the live bank; gated to zero outside EXEC.
  always_comb begin
    j_raw = '0;
    k_raw = '0;
    carry = 1'b1;
    case (op_q)
      OP_LOAD: begin
        j_raw = data_q;
        k_raw = ~data_q;
      end
      OP_CLEAR:  k_raw = '1;
      OP_SET:    j_raw = '1;
      OP_TOGGLE: begin
        j_raw = data_q;
        k_raw = data_q;
      end
      OP_COUNT_UP: begin
        for (int i = 0; i < WIDTH; i++) begin
          j_raw[i] = carry;
          k_raw[i] = carry;
          carry    = carry & bank_q[i];
        end
      end
      OP_COUNT_DOWN: begin
        for (int i = 0; i < WIDTH; i++) begin
          j_raw[i] = carry;
          k_raw[i] = carry;
          carry    = carry & ~bank_q[i];
        end
      end
      OP_SHIFT_LEFT: begin
        j_raw = shift_j;
        k_raw = ~shift_j;
      end
      default: begin
        j_raw = '0;
        k_raw = '0;
      end
    endcase
  end

  always_comb begin
    case (cmd_op)
      OP_NOP:                    n_eff = '0;
      OP_LOAD, OP_CLEAR, OP_SET: n_eff = CNT_W'(1);
      default:                   n_eff = cmd_count;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    aborted_d = aborted_q;
    j_vec     = '0;
    k_vec     = '0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d      = cmd_op;
          data_d    = cmd_data;
          rem_d     = n_eff;
          aborted_d = 1'b0;
          state_d   = (n_eff == '0) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        // Abort wins over the final decrement and freezes the bank this cycle.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          j_vec = j_raw;
          k_vec = k_raw;
          if (rem_q <= CNT_W'(1)) begin
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bank_d    = (j_vec & ~bank_q) | (~k_vec & bank_q);
  assign q         = bank_q;
  assign q_inverse = ~bank_q;
  assign busy      = (state_q != S_IDLE);
  assign aborted   = done & aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      data_q    <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
      bank_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      aborted_q <= aborted_d;
      bank_q    <= bank_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_TOGGLE = 3'd4,
                         OP_COUNT_UP = 3'd5, OP_SHIFT_LEFT = 3'd6, OP_COUNT_DOWN = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic [WIDTH-1:0] j_vec, k_vec, q, q_inverse;
  logic             busy, done, aborted;

  int pass_cnt  = 0;
  int total_cnt = 0;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .abort(abort),
    .j_vec(j_vec), .k_vec(k_vec), .q(q), .q_inverse(q_inverse),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns 1 unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] cnt);
    int n = 0;
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50) $display("FAIL issue_timeout op=%0d cmd_ready never rose", op); else pass_cnt++;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin step(); n++; end
    total_cnt++;
    if (n >= 50) $display("FAIL idle_timeout busy stuck high"); else pass_cnt++;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    issue(OP_LOAD, v, '0);
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cmd_count = '0; abort = 1'b0;
    repeat (2) step();
    total_cnt++; if (q !== 4'b0000) $display("FAIL rst_q got %b exp 0000", q); else pass_cnt++;
    total_cnt++; if (q_inverse !== 4'b1111) $display("FAIL rst_qinv got %b exp 1111", q_inverse); else pass_cnt++;
    total_cnt++; if ({busy, done, aborted} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {busy, done, aborted}); else pass_cnt++;
    total_cnt++; if ({j_vec, k_vec} !== 8'h00) $display("FAIL rst_jk got %h exp 00", {j_vec, k_vec}); else pass_cnt++;
    rst_n = 1'b1;
    step();
    issue(OP_COUNT_UP, '0, 8'd10);
    repeat (3) step();
    total_cnt++; if (q !== 4'b0011) $display("FAIL cnt_before_rst got %b exp 0011", q); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (q !== 4'b0000) $display("FAIL midrst_q got %b exp 0000", q); else pass_cnt++;
    total_cnt++; if (q_inverse !== 4'b1111) $display("FAIL midrst_qinv got %b exp 1111", q_inverse); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL midrst_busy_done got %b exp 00", {busy, done}); else pass_cnt++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if ({done, busy, q} !== 6'b000000) $display("FAIL postrst_idle cyc%0d got %b exp 000000", i, {done, busy, q}); else pass_cnt++;
    end
  endtask

  task automatic test_load();
    issue(OP_LOAD, 4'b1010, 8'd77);
    total_cnt++; if (j_vec !== 4'b1010) $display("FAIL load_j got %b exp 1010", j_vec); else pass_cnt++;
    total_cnt++; if (k_vec !== 4'b0101) $display("FAIL load_k got %b exp 0101", k_vec); else pass_cnt++;
    total_cnt++; if (q !== 4'b0000) $display("FAIL load_q_exec got %b exp 0000", q); else pass_cnt++;
    step();
    total_cnt++; if (q !== 4'b1010) $display("FAIL load_q got %b exp 1010", q); else pass_cnt++;
    total_cnt++; if ({done, aborted} !== 2'b10) $display("FAIL load_done got %b exp 10", {done, aborted}); else pass_cnt++;
    total_cnt++; if ({j_vec, k_vec} !== 8'h00) $display("FAIL load_jk_done got %h exp 00", {j_vec, k_vec}); else pass_cnt++;
    step();
    total_cnt++; if ({done, busy, cmd_ready} !== 3'b001) $display("FAIL load_idle got %b exp 001", {done, busy, cmd_ready}); else pass_cnt++;
  endtask

  task automatic test_count_up();
    logic [WIDTH-1:0] exp_q [4];
    logic             exp_done [4];
    logic             exp_busy [4];
    exp_q    = '{4'b1111, 4'b0000, 4'b0001, 4'b0001};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    load(4'b1110);
    issue(OP_COUNT_UP, '0, 8'd3);
    total_cnt++; if (busy !== 1'b1) $display("FAIL up_busy0 got %b exp 1", busy); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({q, done, busy} !== {exp_q[i], exp_done[i], exp_busy[i]})
        $display("FAIL up_edge%0d got q=%b done=%b busy=%b exp q=%b done=%b busy=%b",
                 i + 1, q, done, busy, exp_q[i], exp_done[i], exp_busy[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_shift_down();
    load(4'b1010);
    issue(OP_SHIFT_LEFT, 4'b0001, 8'd2);
    step();
    total_cnt++; if (q !== 4'b0101) $display("FAIL shl_1 got %b exp 0101", q); else pass_cnt++;
    step();
    total_cnt++; if ({q, done} !== 5'b10111) $display("FAIL shl_2 got %b exp 10111", {q, done}); else pass_cnt++;
    wait_idle();
    load(4'b0000);
    issue(OP_COUNT_DOWN, '0, 8'd1);
    step();
    total_cnt++; if ({q, done} !== 5'b11111) $display("FAIL down_wrap got %b exp 11111", {q, done}); else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    // q is 1111 here; a zero-count COUNT_DOWN then a NOP, valid held continuously.
    cmd_op = OP_COUNT_DOWN; cmd_data = '0; cmd_count = 8'd0; cmd_valid = 1'b1;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready0 got %b exp 1", cmd_ready); else pass_cnt++;
    step();
    total_cnt++; if ({done, cmd_ready, q} !== 6'b101111) $display("FAIL b2b_zero_done got %b exp 101111", {done, cmd_ready, q}); else pass_cnt++;
    cmd_op = OP_NOP;
    step();
    total_cnt++; if ({done, cmd_ready} !== 2'b01) $display("FAIL b2b_gap got %b exp 01", {done, cmd_ready}); else pass_cnt++;
    step();
    total_cnt++; if ({done, cmd_ready, q} !== 6'b101111) $display("FAIL b2b_nop_done got %b exp 101111", {done, cmd_ready, q}); else pass_cnt++;
    cmd_valid = 1'b0;
    step();
    total_cnt++; if ({done, busy, q} !== 6'b001111) $display("FAIL b2b_end got %b exp 001111", {done, busy, q}); else pass_cnt++;
  endtask

  task automatic test_abort();
    load(4'b0000);
    issue(OP_TOGGLE, 4'b0011, 8'd5);
    total_cnt++; if ({j_vec, k_vec} !== 8'h33) $display("FAIL abt_jk got %h exp 33", {j_vec, k_vec}); else pass_cnt++;
    step();
    total_cnt++; if (q !== 4'b0011) $display("FAIL abt_e1 got %b exp 0011", q); else pass_cnt++;
    step();
    total_cnt++; if (q !== 4'b0000) $display("FAIL abt_e2 got %b exp 0000", q); else pass_cnt++;
    abort = 1'b1;
    #1;
    total_cnt++; if ({j_vec, k_vec} !== 8'h00) $display("FAIL abt_jk_forced got %h exp 00", {j_vec, k_vec}); else pass_cnt++;
    step();
    abort = 1'b0;
    total_cnt++; if ({q, done, aborted} !== 6'b000011) $display("FAIL abt_done got %b exp 000011", {q, done, aborted}); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if ({q, done, aborted, busy} !== 7'b0000000) $display("FAIL abt_hold cyc%0d got %b exp 0000000", i, {q, done, aborted, busy}); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_count_up();
    test_shift_down();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
